// File: rtl/mem_port_arbiter.sv
// Two-requester memory port arbiter: instruction fetch (IF) and load/store (LS)
// share one memory port. Round-robin on ties, one transaction in flight,
// wait-cycle timeout with abort, sticky error flag.
module mem_port_arbiter #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        ls_req,
  input  logic [31:0] ls_addr,
  input  logic        ls_we,
  input  logic [31:0] ls_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        if_gnt,
  output logic        ls_gnt,
  output logic        if_done,
  output logic        ls_done,
  output logic [31:0] rd_data,
  output logic        bus_err,
  output logic        err_sticky
);

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_LS} state_t;

  // Wait count at which the next ready-less BUSY cycle is the last one allowed.
  localparam logic [3:0] LP_LAST_WAIT = 4'(TIMEOUT - 1);

  state_t      r_state, w_next;
  logic        r_last_ls;   // 1: LS was granted last, so IF wins the next tie
  logic [3:0]  r_wait;
  logic        w_pick_ls, w_grant, w_ok, w_abort;

  logic        r_mem_en, r_mem_we, r_if_gnt, r_ls_gnt, r_if_done, r_ls_done;
  logic        r_bus_err, r_err_sticky;
  logic [31:0] r_mem_addr, r_mem_wdata, r_rd_data;

  // Next state plus grant / completion / abort decisions for this edge.
  always_comb begin
    w_next    = r_state;
    w_grant   = 1'b0;
    w_ok      = 1'b0;
    w_abort   = 1'b0;
    w_pick_ls = ls_req && (!if_req || !r_last_ls);
    case (r_state)
      IDLE: begin
        if (if_req || ls_req) begin
          w_grant = 1'b1;
          w_next  = w_pick_ls ? BUSY_LS : BUSY_IF;
        end
      end
      BUSY_IF, BUSY_LS: begin
        // Ready wins over timeout when both land on the same cycle.
        if (mem_ready) begin
          w_ok   = 1'b1;
          w_next = IDLE;
        end else if (r_wait == LP_LAST_WAIT) begin
          w_abort = 1'b1;
          w_next  = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Memory-side command, wait counter and round-robin pointer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last_ls   <= 1'b1;
      r_wait      <= 4'd0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= 32'd0;
      r_mem_wdata <= 32'd0;
    end else begin
      r_mem_en <= (w_next != IDLE);
      if (w_grant) begin
        r_last_ls   <= w_pick_ls;
        r_wait      <= 4'd0;
        r_mem_addr  <= w_pick_ls ? ls_addr : if_addr;
        r_mem_we    <= w_pick_ls & ls_we;
        r_mem_wdata <= w_pick_ls ? ls_wdata : 32'd0;
      end else begin
        if (r_state != IDLE && !mem_ready) r_wait <= r_wait + 4'd1;
        // Never leave a write strobe up while the port is idle.
        if (w_ok || w_abort) r_mem_we <= 1'b0;
      end
    end
  end

  // Requester-side pulses, read data capture and sticky error.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_if_gnt     <= 1'b0;
      r_ls_gnt     <= 1'b0;
      r_if_done    <= 1'b0;
      r_ls_done    <= 1'b0;
      r_bus_err    <= 1'b0;
      r_err_sticky <= 1'b0;
      r_rd_data    <= 32'd0;
    end else begin
      r_if_gnt  <= w_grant && !w_pick_ls;
      r_ls_gnt  <= w_grant && w_pick_ls;
      r_if_done <= (w_ok || w_abort) && (r_state == BUSY_IF);
      r_ls_done <= (w_ok || w_abort) && (r_state == BUSY_LS);
      r_bus_err <= w_abort;
      if (w_abort) begin
        r_rd_data    <= 32'd0;
        r_err_sticky <= 1'b1;
      end else if (w_ok && !r_mem_we) begin
        r_rd_data <= mem_rdata;
      end
    end
  end

  assign mem_en     = r_mem_en;
  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign if_gnt     = r_if_gnt;
  assign ls_gnt     = r_ls_gnt;
  assign if_done    = r_if_done;
  assign ls_done    = r_ls_done;
  assign rd_data    = r_rd_data;
  assign bus_err    = r_bus_err;
  assign err_sticky = r_err_sticky;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized transactions
// checked against a transaction-level model (round-robin pointer, latency
// arithmetic, expected read data and sticky error).
module tb_mem_port_arbiter;
  localparam int TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, ls_req, ls_we, mem_ready;
  logic [31:0] if_addr, ls_addr, ls_wdata, mem_rdata;
  logic        mem_en, mem_we, if_gnt, ls_gnt, if_done, ls_done, bus_err, err_sticky;
  logic [31:0] mem_addr, mem_wdata, rd_data;

  int errors = 0;
  int checks = 0;

  // Model state
  bit          m_last_ls;
  bit          m_sticky;
  logic [31:0] m_rd;

  mem_port_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr),
    .ls_req(ls_req), .ls_addr(ls_addr), .ls_we(ls_we), .ls_wdata(ls_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .if_gnt(if_gnt), .ls_gnt(ls_gnt), .if_done(if_done), .ls_done(ls_done),
    .rd_data(rd_data), .bus_err(bus_err), .err_sticky(err_sticky)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".mem_en"},     32'(mem_en),     0);
    chk({tag, ".mem_we"},     32'(mem_we),     0);
    chk({tag, ".mem_addr"},   mem_addr,        0);
    chk({tag, ".mem_wdata"},  mem_wdata,       0);
    chk({tag, ".if_gnt"},     32'(if_gnt),     0);
    chk({tag, ".ls_gnt"},     32'(ls_gnt),     0);
    chk({tag, ".if_done"},    32'(if_done),    0);
    chk({tag, ".ls_done"},    32'(ls_done),    0);
    chk({tag, ".rd_data"},    rd_data,         0);
    chk({tag, ".bus_err"},    32'(bus_err),    0);
    chk({tag, ".err_sticky"}, 32'(err_sticky), 0);
  endtask

  // One complete transaction starting from IDLE. w = wait cycles before
  // mem_ready (ready arrives in BUSY cycle w+1); w >= TIMEOUT means abort.
  task automatic do_txn(input string tag, input bit rif, input bit rls, input bit we,
                        input logic [31:0] aif, input logic [31:0] als,
                        input logic [31:0] wd, input logic [31:0] rd,
                        input int w, input bit drop);
    bit win_ls, tout;
    int n;
    win_ls    = rls && (!rif || !m_last_ls);
    m_last_ls = win_ls;
    tout      = (w >= TIMEOUT);
    n         = tout ? TIMEOUT : w + 1;

    if_req = rif; ls_req = rls; if_addr = aif; ls_addr = als;
    ls_we = we; ls_wdata = wd; mem_ready = 1'b0; mem_rdata = $urandom;
    tick();
    chk({tag, ".if_gnt"},    32'(if_gnt),  32'(!win_ls));
    chk({tag, ".ls_gnt"},    32'(ls_gnt),  32'(win_ls));
    chk({tag, ".mem_en"},    32'(mem_en),  1);
    chk({tag, ".mem_we"},    32'(mem_we),  32'(win_ls && we));
    chk({tag, ".mem_addr"},  mem_addr,     win_ls ? als : aif);
    chk({tag, ".mem_wdata"}, mem_wdata,    win_ls ? wd : 32'd0);
    if (drop) begin
      if (win_ls) ls_req = 1'b0;
      else        if_req = 1'b0;
    end

    for (int k = 1; k <= n; k++) begin
      mem_ready = (k == w + 1);
      mem_rdata = mem_ready ? rd : $urandom;
      tick();
      if (k < n) begin
        chk({tag, ".busy_done"}, 32'({if_done, ls_done}), 0);
        chk({tag, ".busy_en"},   32'(mem_en), 1);
        chk({tag, ".busy_gnt"},  32'({if_gnt, ls_gnt}), 0);
      end
    end

    if (tout) begin
      m_rd = 32'd0;
      m_sticky = 1'b1;
    end else if (!(win_ls && we)) begin
      m_rd = rd;
    end
    chk({tag, ".if_done"},    32'(if_done),    32'(!win_ls));
    chk({tag, ".ls_done"},    32'(ls_done),    32'(win_ls));
    chk({tag, ".bus_err"},    32'(bus_err),    32'(tout));
    chk({tag, ".rd_data"},    rd_data,         m_rd);
    chk({tag, ".err_sticky"}, 32'(err_sticky), 32'(m_sticky));
    chk({tag, ".done_en"},    32'(mem_en),     0);

    // Requesters drop; mem_ready noise in IDLE must be ignored.
    if_req = 1'b0; ls_req = 1'b0;
    mem_ready = 1'($urandom);
    mem_rdata = $urandom;
    tick();
    chk({tag, ".idle_en"},   32'(mem_en), 0);
    chk({tag, ".idle_pls"},  32'({if_gnt, ls_gnt, if_done, ls_done, bus_err}), 0);
    chk({tag, ".idle_rd"},   rd_data, m_rd);
    mem_ready = 1'b0;
  endtask

  initial begin
    bit exp_ls;
    reset = 1'b1;
    if_req = 0; ls_req = 0; ls_we = 0; mem_ready = 0;
    if_addr = 0; ls_addr = 0; ls_wdata = 0; mem_rdata = 0;
    m_last_ls = 1'b1; m_sticky = 1'b0; m_rd = 32'd0;
    #3;
    chk_all_zero("reset");
    #14;
    reset = 1'b0;
    tick();
    chk_all_zero("post_reset");

    // Simultaneous requests with mem_ready held: IF, LS, IF, LS.
    if_req = 1; ls_req = 1; if_addr = 32'h200; ls_addr = 32'h300;
    mem_ready = 1; mem_rdata = 32'hCAFE0001;
    for (int t = 0; t < 8; t++) begin
      tick();
      if (t % 2 == 0) begin
        exp_ls = !m_last_ls;
        m_last_ls = exp_ls;
        chk("rr.if_gnt", 32'(if_gnt), 32'(!exp_ls));
        chk("rr.ls_gnt", 32'(ls_gnt), 32'(exp_ls));
        chk("rr.addr",   mem_addr, exp_ls ? 32'h300 : 32'h200);
        chk("rr.g_done", 32'({if_done, ls_done}), 0);
      end else begin
        chk("rr.if_done", 32'(if_done), 32'(!m_last_ls));
        chk("rr.ls_done", 32'(ls_done), 32'(m_last_ls));
        chk("rr.d_gnt",   32'({if_gnt, ls_gnt}), 0);
      end
    end
    m_rd = 32'hCAFE0001;
    if_req = 0; ls_req = 0; mem_ready = 0;
    tick();
    chk("rr.rd_data", rd_data, m_rd);

    // Store: rd_data unchanged.
    do_txn("store", 0, 1, 1, 32'h0, 32'h40, 32'hDEADBEEF, 32'h55555555, 2, 0);
    // Fetch with 3 wait cycles.
    do_txn("fetch_w3", 1, 0, 0, 32'h100, 32'h0, 32'h0, 32'h12345678, 3, 0);
    // Ready exactly on the last allowed cycle: success.
    do_txn("edge_ok", 1, 0, 0, 32'h104, 32'h0, 32'h0, 32'hA5A5A5A5, TIMEOUT - 1, 0);
    // Requester drops during BUSY; transaction still completes.
    do_txn("drop", 0, 1, 0, 32'h0, 32'h80, 32'h1, 32'h0BADF00D, 4, 1);
    // Timeout abort.
    do_txn("timeout", 1, 0, 0, 32'h100, 32'h0, 32'h0, 32'h99999999, TIMEOUT, 0);

    for (int i = 0; i < 30; i++) begin
      int w;
      w = ($urandom_range(0, 7) == 0) ? $urandom_range(TIMEOUT, TIMEOUT + 2)
                                      : $urandom_range(0, TIMEOUT - 1);
      do_txn($sformatf("rnd%0d", i), 1'($urandom), 1'b1, 1'($urandom),
             $urandom, $urandom, $urandom, $urandom, w, 1'($urandom));
    end

    // Reset in the middle of a load/store transaction.
    ls_req = 1; ls_we = 1; ls_addr = 32'h44; ls_wdata = 32'h77; mem_ready = 0;
    tick();
    m_last_ls = 1'b1;
    chk("rst_mid.gnt", 32'(ls_gnt), 1);
    tick();
    #2 reset = 1'b1;
    #1;
    chk_all_zero("rst_mid");
    m_last_ls = 1'b1; m_sticky = 1'b0; m_rd = 32'd0;
    @(posedge clk); #1;
    chk_all_zero("rst_hold");
    #2 reset = 1'b0;
    tick();
    chk("rst_rel.ls_gnt",  32'(ls_gnt),  1);
    chk("rst_rel.ls_done", 32'(ls_done), 0);
    chk("rst_rel.addr",    mem_addr,     32'h44);
    mem_ready = 1;
    tick();
    chk("rst_rel.done",    32'(ls_done), 1);
    chk("rst_rel.sticky",  32'(err_sticky), 0);
    chk("rst_rel.rd",      rd_data, m_rd);
    ls_req = 0; mem_ready = 0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15, giving the max BUSY cycles without mem_ready before abort (1..15).
REQ-002 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have ports if_req / ls_req  input  1 each  fetch / load-store request, held until matching done.
REQ-005 SHALL have ports if_addr / ls_addr  input  32 each  request addresses.
REQ-006 SHALL have ports ls_we  input  1 (store=1) and ls_wdata  input  32 (store data).
REQ-007 SHALL have ports mem_rdata  input  32 and mem_ready  input  1, the memory response.
REQ-008 SHALL have ports mem_en, mem_we  output  1 each; mem_addr, mem_wdata  output  32 each; all registered.
REQ-009 SHALL have ports if_gnt, ls_gnt, if_done, ls_done  output  1 each, registered one-cycle pulses.
REQ-010 SHALL have ports rd_data  output  32 (read result) and bus_err  output  1 (pulse with done on abort).
REQ-011 SHALL have port err_sticky  output  1, latched abort indicator.

Function
REQ-012 SHALL implement FSM states IDLE, BUSY_IF, BUSY_LS; one transaction outstanding at a time.
REQ-013 In IDLE with any req high at an edge, SHALL enter BUSY_x for the winner and latch its addr/we/wdata onto mem_* at that edge.
REQ-014 Fetch transactions SHALL drive mem_we=0 and mem_wdata=0.
REQ-015 Arbitration SHALL be round-robin via last_grant register: on simultaneous requests, grant the requester not granted last; a single request wins regardless.
REQ-016 last_grant SHALL update only on grant.
REQ-017 gnt for the winner SHALL be high exactly in the first BUSY cycle.
REQ-018 mem_en SHALL be 1 in every BUSY cycle and 0 in IDLE.
REQ-019 mem_ready SHALL be sampled only in BUSY; when high at an edge, SHALL capture mem_rdata into rd_data (reads only; stores leave rd_data unchanged), pulse done for the cycle after, and return to IDLE.
REQ-020 Minimum latency: req at edge 0, mem_ready high in cycle 1 -> done high in cycle 2; next grant earliest at edge 2 (done cycle is IDLE).
REQ-021 A 4-bit wait counter SHALL clear on BUSY entry and increment per BUSY cycle without mem_ready.
REQ-022 When the counter reaches TIMEOUT without mem_ready, SHALL abort: done and bus_err pulse next cycle, rd_data set to 0, err_sticky set to 1, state returns to IDLE.
REQ-023 mem_ready in the same cycle the counter reaches TIMEOUT SHALL count as success, not abort.
REQ-024 Requester dropping req during BUSY SHALL be ignored; the transaction completes and done still pulses.
REQ-025 mem_ready in IDLE SHALL be ignored.
REQ-026 Requests arriving while BUSY SHALL wait; they are arbitrated in the next IDLE cycle.
REQ-027 err_sticky SHALL clear only on reset.

Reset
REQ-028 On reset assertion, all outputs SHALL go to 0 immediately, regardless of clk.
REQ-029 On reset assertion, state SHALL go to IDLE, the wait counter to 0, and last_grant to LS (so IF wins the first tie).
REQ-030 Reset mid-transaction SHALL abandon it with no done pulse; a request still held after reset deasserts is re-arbitrated.

Verification
REQ-031 Simultaneous if_req/ls_req after reset, mem_ready held 1 -> order IF, LS, IF, LS; each done two cycles after its grant edge.
REQ-032 ls_req, ls_we=1, ls_addr=0x40, ls_wdata=0xDEADBEEF -> mem_we=1, mem_addr=0x40, mem_wdata=0xDEADBEEF during BUSY; ls_done pulse; rd_data unchanged.
REQ-033 if_req addr 0x100, mem_ready after 3 wait cycles with mem_rdata=0x12345678 -> if_done one cycle after mem_ready; rd_data=0x12345678; bus_err=0.
REQ-034 if_req, mem_ready never asserted -> if_done and bus_err pulse after 15 BUSY cycles; rd_data=0; err_sticky=1 until reset.
REQ-035 Reset asserted mid BUSY_LS -> outputs 0 asynchronously; no ls_done; held ls_req re-granted after reset release.
